// File: rtl/seq_cmd_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_cmd_streamer_pkg                                                       |
// | Opcodes, time-word width and frame lengths shared with the generator.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package seq_cmd_streamer_pkg;

   localparam int BIT_NUM_DEF = 48;

   typedef logic [7:0] byte_t;

   typedef enum logic [7:0] {
      M_IDLE       = 8'h00,
      M_CMD_ARM    = 8'h01,
      M_SET_PERIOD = 8'h02,
      M_LOAD_EVENT = 8'h03,
      M_ABORT      = 8'h0F
   } opcode_e;

   // Payload bytes following the opcode; zero for single-byte commands.
   function automatic int payloadLen(input byte_t op, input int timeBytes);
      case (op)
         M_SET_PERIOD: return timeBytes;
         M_LOAD_EVENT: return timeBytes + 2;
         default:      return 0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_cmd_streamer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_cmd_streamer_if                                                        |
// | Byte stream from the host FIFO into the command streamer.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface seq_cmd_streamer_if;
   import seq_cmd_streamer_pkg::*;

   byte_t iRX_DATA;
   logic  iRX_VALID;
   logic  oRX_READY;

   modport master (output iRX_DATA, output iRX_VALID, input oRX_READY);
   modport slave  (input iRX_DATA, input iRX_VALID, output oRX_READY);

endinterface
`default_nettype wire

// File: rtl/seq_cmd_streamer_byte_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_byte_shifter                                                           |
// | Byte-to-word shift register with a remaining-byte counter.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_byte_shifter #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 4
) (
   input  wire logic             iCLK,
   input  wire logic             iNRST,
   input  logic                  i_load,
   input  logic [CNT_W-1:0]      i_len,
   input  logic                  i_shift,
   input  logic [7:0]            i_byte,
   output logic [WIDTH-1:0]      o_nextWord,
   output logic                  o_last
);

   logic [WIDTH-9:0] r_word;
   logic [CNT_W-1:0] r_cnt;

   // Word as it will look once the incoming byte lands, so a commit can use it directly.
   assign o_nextWord = {r_word, i_byte};
   assign o_last     = i_shift && (r_cnt == CNT_W'(1));

   always_ff @(posedge iCLK or negedge iNRST) begin
      if (!iNRST) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_word <= '0;
         r_cnt  <= i_len;
      end else if (i_shift) begin
         r_word <= o_nextWord[WIDTH-9:0];
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_cmd_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_cmd_streamer                                                           |
// | Parses framed host commands and drives the generator mode/data/flag bus.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_cmd_streamer
   import seq_cmd_streamer_pkg::*;
#(
   parameter int BIT_NUM   = BIT_NUM_DEF,
   parameter int SETUP_CYC = 2,
   parameter int FLAG_HOLD = 4,
   parameter int MODE_HOLD = 4,
   parameter int TIMEOUT   = 1023
) (
   input  wire logic           iCLK,
   input  wire logic           iNRST,
   seq_cmd_streamer_if.slave   rx,
   input  logic                iARMED,
   output logic [7:0]          oCTRL_MODE,
   output logic                oFLAG_TIME_READY,
   output logic                oFLAG_CH_VAL_READY,
   output logic [7:0]          oDATA_CHANNEL,
   output logic [BIT_NUM-1:0]  oDATA_TIME,
   output logic                oDATA_CH_VAL,
   output logic                oBUSY,
   output logic                oERR,
   output logic [7:0]          oSTATUS
);

   localparam logic [3:0] c_ST_OPC     = 4'd0;
   localparam logic [3:0] c_ST_COLLECT = 4'd1;
   localparam logic [3:0] c_ST_SETUP   = 4'd2;
   localparam logic [3:0] c_ST_FLAG    = 4'd3;
   localparam logic [3:0] c_ST_HOLD    = 4'd4;

   localparam int c_TIME_BYTES = BIT_NUM / 8;
   localparam int c_WORD_W     = BIT_NUM + 16;
   localparam int c_LEN_W      = $clog2(c_TIME_BYTES + 3);
   localparam int c_MAX_HOLD   = (SETUP_CYC > FLAG_HOLD)
                               ? ((SETUP_CYC > MODE_HOLD) ? SETUP_CYC : MODE_HOLD)
                               : ((FLAG_HOLD > MODE_HOLD) ? FLAG_HOLD : MODE_HOLD);
   localparam int c_CNT_W      = $clog2(c_MAX_HOLD + 1);
   localparam int c_TO_W       = $clog2(TIMEOUT + 2);

   logic [3:0]          r_state;
   logic [7:0]          r_mode;
   logic [7:0]          r_opcode;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_TO_W-1:0]   r_idle;
   logic                r_flagTime;
   logic                r_flagChVal;
   logic [7:0]          r_channel;
   logic [BIT_NUM-1:0]  r_time;
   logic                r_chVal;
   logic                r_err;
   logic                r_rxReady;

   logic                w_accept;
   logic                w_isPayload;
   logic                w_load;
   logic                w_shift;
   logic                w_last;
   logic [c_LEN_W-1:0]  w_len;
   logic [c_WORD_W-1:0] w_nextWord;

   assign w_accept    = rx.iRX_VALID && r_rxReady;
   assign w_isPayload = (rx.iRX_DATA == M_SET_PERIOD) || (rx.iRX_DATA == M_LOAD_EVENT);
   assign w_load      = w_accept && (r_state == c_ST_OPC) && w_isPayload;
   assign w_shift     = w_accept && (r_state == c_ST_COLLECT);
   assign w_len       = c_LEN_W'(payloadLen(rx.iRX_DATA, c_TIME_BYTES));

   seq_byte_shifter #(
      .WIDTH (c_WORD_W),
      .CNT_W (c_LEN_W)
   ) u_shifter (
      .iCLK       (iCLK),
      .iNRST      (iNRST),
      .i_load     (w_load),
      .i_len      (w_len),
      .i_shift    (w_shift),
      .i_byte     (rx.iRX_DATA),
      .o_nextWord (w_nextWord),
      .o_last     (w_last)
   );

   always_ff @(posedge iCLK or negedge iNRST) begin
      if (!iNRST) begin
         r_state     <= c_ST_OPC;
         r_mode      <= M_IDLE;
         r_opcode    <= M_IDLE;
         r_cnt       <= '0;
         r_idle      <= '0;
         r_flagTime  <= 1'b0;
         r_flagChVal <= 1'b0;
         r_channel   <= '0;
         r_time      <= '0;
         r_chVal     <= 1'b0;
         r_err       <= 1'b0;
         r_rxReady   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            c_ST_OPC: begin
               r_rxReady <= 1'b1;
               if (w_accept) begin
                  case (rx.iRX_DATA)
                     M_IDLE: ;
                     M_SET_PERIOD, M_LOAD_EVENT: begin
                        r_opcode <= rx.iRX_DATA;
                        r_idle   <= '0;
                        r_state  <= c_ST_COLLECT;
                     end
                     M_CMD_ARM, M_ABORT: begin
                        r_mode    <= rx.iRX_DATA;
                        r_cnt     <= c_CNT_W'(MODE_HOLD - 1);
                        r_rxReady <= 1'b0;
                        r_state   <= c_ST_HOLD;
                     end
                     default: r_err <= 1'b1;
                  endcase
               end
            end
            c_ST_COLLECT: begin
               if (w_shift) begin
                  r_idle <= '0;
                  if (w_last) begin
                     // Commit: data and mode move together, flags are still low here.
                     if (r_opcode == M_LOAD_EVENT) begin
                        r_channel <= w_nextWord[c_WORD_W-1 -: 8];
                        r_time    <= w_nextWord[BIT_NUM+7:8];
                        r_chVal   <= w_nextWord[0];
                     end else begin
                        r_time    <= w_nextWord[BIT_NUM-1:0];
                     end
                     r_mode    <= r_opcode;
                     r_cnt     <= c_CNT_W'(SETUP_CYC - 1);
                     r_rxReady <= 1'b0;
                     r_state   <= c_ST_SETUP;
                  end
               end else if (TIMEOUT != 0) begin
                  if (r_idle == c_TO_W'(TIMEOUT - 1)) begin
                     r_err   <= 1'b1;
                     r_state <= c_ST_OPC;
                  end else begin
                     r_idle <= r_idle + c_TO_W'(1);
                  end
               end
            end
            c_ST_SETUP: begin
               if (r_cnt == '0) begin
                  r_flagTime  <= 1'b1;
                  r_flagChVal <= (r_opcode == M_LOAD_EVENT);
                  r_cnt       <= c_CNT_W'(FLAG_HOLD - 1);
                  r_state     <= c_ST_FLAG;
               end else begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            c_ST_FLAG: begin
               if (r_cnt == '0) begin
                  r_flagTime  <= 1'b0;
                  r_flagChVal <= 1'b0;
                  r_cnt       <= c_CNT_W'(MODE_HOLD - 1);
                  r_state     <= c_ST_HOLD;
               end else begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            c_ST_HOLD: begin
               if (r_cnt == '0) begin
                  r_mode    <= M_IDLE;
                  r_rxReady <= 1'b1;
                  r_state   <= c_ST_OPC;
               end else begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            default: begin
               r_mode      <= M_IDLE;
               r_flagTime  <= 1'b0;
               r_flagChVal <= 1'b0;
               r_rxReady   <= 1'b1;
               r_state     <= c_ST_OPC;
            end
         endcase
      end
   end

   assign rx.oRX_READY       = r_rxReady;
   assign oCTRL_MODE         = r_mode;
   assign oFLAG_TIME_READY   = r_flagTime;
   assign oFLAG_CH_VAL_READY = r_flagChVal;
   assign oDATA_CHANNEL      = r_channel;
   assign oDATA_TIME         = r_time;
   assign oDATA_CH_VAL       = r_chVal;
   assign oBUSY              = (r_state != c_ST_OPC);
   assign oERR               = r_err;
   assign oSTATUS            = {iARMED, 3'b000, r_state};

endmodule
`default_nettype wire
